// File: rtl/pe_select_stream.sv
// pe_select_stream: streaming per-site substitution-row selector.
// Each accepted word carries N_SITES 2-bit nucleotide codes and a gap mask.
// Each site is mapped to one row of a double-buffered 4-row probability matrix.
// The selected word is queued in a 2-entry output FIFO with valid/ready handshakes.
module pe_select_stream #(
   parameter int                N_SITES = 16,
   parameter int                ROW_W   = 40,
   parameter logic [ROW_W-1:0]  GAP_ROW = {ROW_W{1'b1}}
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       mat_wr_en,
   input  logic [1:0]                 mat_wr_row,
   input  logic [ROW_W-1:0]           mat_wr_data,
   input  logic                       mat_swap,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2*N_SITES-1:0]       in_nucl,
   input  logic [N_SITES-1:0]         in_gap,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N_SITES*ROW_W-1:0]   out_rows,
   output logic                       out_last,
   output logic [15:0]                word_count
);

   // Matrix banks: shadow is written by the loader, active feeds selection.
   logic [ROW_W-1:0]          r_shadow [4];
   logic [ROW_W-1:0]          r_active [4];
   logic [ROW_W-1:0]          w_shadow_nx [4];

   // Output FIFO storage and pointers.
   logic [N_SITES*ROW_W-1:0]  r_fifo_rows [2];
   logic                      r_fifo_last [2];
   logic                      r_wr_ptr;
   logic                      r_rd_ptr;
   logic [1:0]                r_count;
   logic [15:0]               r_word_count;

   logic                      w_in_ready;
   logic                      w_out_valid;
   logic                      w_accept;
   logic                      w_pop;
   logic [N_SITES*ROW_W-1:0]  w_sel_rows;

   // Handshake decode from registered FIFO occupancy only.
   assign w_in_ready  = (r_count != 2'd2);
   assign w_out_valid = (r_count != 2'd0);
   assign w_accept    = in_valid && w_in_ready;
   assign w_pop       = w_out_valid && out_ready;

   assign in_ready    = w_in_ready;
   assign out_valid   = w_out_valid;
   assign out_rows    = r_fifo_rows[r_rd_ptr];
   assign out_last    = r_fifo_last[r_rd_ptr];
   assign word_count  = r_word_count;

   // Per-site row selection from the currently active matrix (gap overrides code).
   always_comb begin
      w_sel_rows = '0;
      for (int i = 0; i < N_SITES; i++) begin
         if (in_gap[i]) begin
            w_sel_rows[i*ROW_W +: ROW_W] = GAP_ROW;
         end else begin
            w_sel_rows[i*ROW_W +: ROW_W] = r_active[in_nucl[2*i +: 2]];
         end
      end
   end

   // Shadow contents after this cycle's write, so a same-cycle swap picks up the new row.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         w_shadow_nx[r] = r_shadow[r];
      end
      if (mat_wr_en) begin
         w_shadow_nx[mat_wr_row] = mat_wr_data;
      end
   end

   // Matrix banks: load shadow rows, copy to active on swap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < 4; r++) begin
            r_shadow[r] <= '0;
            r_active[r] <= '0;
         end
      end else begin
         for (int r = 0; r < 4; r++) begin
            r_shadow[r] <= w_shadow_nx[r];
            if (mat_swap) begin
               r_active[r] <= w_shadow_nx[r];
            end
         end
      end
   end

   // Output FIFO: push the selected word on accept, advance the head on pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int e = 0; e < 2; e++) begin
            r_fifo_rows[e] <= '0;
            r_fifo_last[e] <= 1'b0;
         end
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_accept) begin
            r_fifo_rows[r_wr_ptr] <= w_sel_rows;
            r_fifo_last[r_wr_ptr] <= in_last;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Words accepted in the current alignment block; cleared by a last word, saturating.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_word_count <= 16'd0;
      end else if (w_accept) begin
         if (in_last) begin
            r_word_count <= 16'd0;
         end else if (r_word_count != 16'hFFFF) begin
            r_word_count <= r_word_count + 16'd1;
         end
      end
   end

endmodule

// File: doc/pe_select_stream.md
# pe_select_stream

Streaming, parametrised successor to the per-site probability selector. Each accepted word carries N_SITES 2-bit nucleotide codes (A=00, C=01, G=10, T=11) plus a per-site gap mask. For every site the block emits the matching ROW_W-bit row of a 4-row substitution-probability matrix. The matrix is double-buffered: a new branch matrix can be loaded while the current one is in use. Input and output use valid/ready handshakes, with a 2-entry output FIFO. The block sits between the alignment fetch and the likelihood multiply stages.

## Interface
- N_SITES, 16, sites per word
- ROW_W, 40, bits per matrix row (A row is row 0, T row is row 3)
- GAP_ROW, {ROW_W{1'b1}}, row emitted for gap/unknown sites
- clk  in  1  clock, rising edge
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- mat_wr_en  in  1  write one row of the shadow matrix
- mat_wr_row  in  2  shadow row index
- mat_wr_data  in  ROW_W  row data
- mat_swap  in  1  copy shadow matrix into active matrix
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_nucl  in  2*N_SITES  site i code at [2i+1:2i]
- in_gap  in  N_SITES  site i is a gap when bit i = 1
- in_last  in  1  last word of an alignment block
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- out_rows  out  N_SITES*ROW_W  site i row at [i*ROW_W +: ROW_W]
- out_last  out  1  in_last of the word on out_rows
- word_count  out  16  words accepted in the current block

## Operation
- Accept: in_valid && in_ready at a rising edge.
- Selection at accept time. For each site i, the result is GAP_ROW if in_gap[i], else active[in_nucl[2i+1:2i]].
- The selected word and in_last are pushed into a 2-entry FIFO (count 0..2). in_ready = (count != 2) and depends on registered state only.
- Pop: out_valid && out_ready. out_valid = (count != 0). out_rows/out_last show the FIFO head.
- Push and pop in the same cycle: count is unchanged, order is preserved.
- Matrix write: mat_wr_en writes mat_wr_data to shadow[mat_wr_row].
- Matrix swap: mat_swap sets active = shadow at the same edge.
  - Same-cycle write and swap: the swap copies the post-write shadow, so the new row reaches active.
  - A word accepted in the same cycle as a swap uses the old active matrix. Words already in the FIFO are never altered.
- word_count increments on each accept and saturates at 16'hFFFF. If the accepted word has in_last=1, word_count becomes 0 at that edge instead.

## Timing
- Reset (reset_n low, asynchronous):
  - FIFO count = 0, out_valid = 0, out_rows = 0, out_last = 0, word_count = 0.
  - Both matrix banks = 0.
  - in_ready = 1.
- Latency: a word accepted at edge k is on out_rows with out_valid=1 after edge k (one cycle) if the FIFO was empty. Otherwise it appears behind the older entries.
- Throughput: 1 word/cycle while out_ready=1.
- Full: when out_ready is held 0, the FIFO fills with 2 words and in_ready drops to 0 after the second accept. in_ready returns to 1 the cycle after the first pop.
- Backpressure: out_rows and out_last are stable while out_valid=1 and out_ready=0.
- Empty: out_ready is ignored when out_valid=0.
- Reset mid-operation: FIFO contents are discarded immediately, with no partial word output. The matrix must be reloaded.
- Invalid input: in_nucl and in_gap are ignored when in_valid=0.

## Test plan
- Load rows A=0x0101010101, C=0x0202020202, G=0x0303030303, T=0x0404040404, then swap. Send in_nucl=32'h1B1B1B1B with out_ready=1 -> out_valid one cycle later. Site pattern per byte is T,G,C,A from site 0 upward, so site0=0x0404040404, site1=0x0303030303, site2=0x0202020202, site3=0x0101010101, repeating.
- Same matrix, in_nucl=0, in_gap=16'h0001 -> site0=GAP_ROW, sites 1..15=0x0101010101.
- Hold out_ready=0 and offer 3 words -> 2 accepted, in_ready=0, out_rows stable on the first word. Raise out_ready -> words drain in order and the third word is accepted.
- While words are streaming, write shadow A=0xAAAAAAAAAA and pulse mat_swap together with an accept of in_nucl=0 -> that word shows old A rows and the next word shows 0xAAAAAAAAAA.
- Accept 5 words, the 5th with in_last=1 -> word_count goes 1,2,3,4, then 0. out_last=1 only on the 5th output.
- Assert reset_n=0 with 2 words queued -> out_valid=0, word_count=0 and in_ready=1 immediately. After release, output row reads 0 until the matrix is reloaded.
